// File: rtl/phase_generator.sv
`default_nettype none
// ============================================================================
// Module      : phase_generator
// Description : NCO phase accumulator for the CDR. It emits an 8-bit sampling
//               phase code that advances by FCW every clock and wraps mod 256.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_generator #(
    parameter int          ACC_WIDTH    = 16,
    parameter logic [31:0] FCW          = 32'h0000_0100,
    parameter logic [7:0]  PHASE_OFFSET = 8'h00,
    parameter bit          ROUND        = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] phase
);

    localparam logic [63:0]          c_fcw_ext = 64'(FCW);
    localparam logic [ACC_WIDTH-1:0] c_fcw     = ACC_WIDTH'(FCW);
    localparam logic [ACC_WIDTH-1:0] c_rst_val = ACC_WIDTH'(PHASE_OFFSET) << (ACC_WIDTH - 8);

    if ((ACC_WIDTH < 8) || (ACC_WIDTH > 32)) begin : g_bad_width
        $error("phase_generator: ACC_WIDTH=%0d outside legal range 8..32", ACC_WIDTH);
    end

    if ((c_fcw_ext >> ACC_WIDTH) != 64'd0) begin : g_bad_fcw
        $error("phase_generator: FCW=0x%0h does not fit in ACC_WIDTH=%0d bits", FCW, ACC_WIDTH);
    end

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

    // Carry out of the top bit is dropped, giving the modulo-2^ACC_WIDTH wrap.
    always_comb begin
        acc_d = acc_q + c_fcw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= c_rst_val;
        end else begin
            acc_q <= acc_d;
        end
    end

    if (ROUND && (ACC_WIDTH > 8)) begin : g_round
        // Half-up rounding on the first bit below the output slice; 255.5 wraps to 0.
        assign phase = acc_q[ACC_WIDTH-1 -: 8] + {7'b000_0000, acc_q[ACC_WIDTH-9]};
    end else begin : g_trunc
        assign phase = acc_q[ACC_WIDTH-1 -: 8];
    end

    // Fractional bits feed only the carry chain (and, when rounding, one bit of the output).
    logic w_unused_frac;
    assign w_unused_frac = ^acc_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_generator
// Description : Bench for phase_generator; several parameterisations run in
//               lockstep against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_generator;

    localparam int NUM = 7;

    // Per-instance configuration: defaults, fractional FCW (trunc/round),
    // non-zero offset, FCW=0, narrowest accumulator, widest accumulator.
    localparam int          CW [NUM] = '{16, 16, 16, 16, 16, 8, 32};
    localparam logic [31:0] CF [NUM] = '{32'h0100, 32'h0180, 32'h0180, 32'h0100,
                                         32'h0000, 32'h0007, 32'h0123_4567};
    localparam logic [7:0]  CO [NUM] = '{8'h00, 8'h00, 8'h00, 8'hF0, 8'h5A, 8'h10, 8'hC3};
    localparam bit          CR [NUM] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] phase_obs [NUM];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    longint unsigned n_inc  = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NUM; k++) begin : g_dut
        phase_generator #(
            .ACC_WIDTH   (CW[k]),
            .FCW         (CF[k]),
            .PHASE_OFFSET(CO[k]),
            .ROUND       (CR[k])
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .phase(phase_obs[k])
        );
    end

    // Number of increments since the most recent reset edge.
    always @(posedge clk) begin
        if (rst) n_inc <= 0;
        else     n_inc <= n_inc + 1;
    end

    // Phase as a real-valued fraction of one UI: (offset + n*FCW) mod 2^W,
    // scaled to 256 steps, then truncated or rounded half-up.
    function automatic logic [7:0] model(input int k, input longint unsigned n);
        longint unsigned modv;
        longint unsigned scale;
        longint unsigned acc;
        modv  = 64'd1 << CW[k];
        scale = 64'd1 << (CW[k] - 8);
        acc   = (longint'(CO[k]) * scale + n * longint'(CF[k])) % modv;
        if (CR[k] && (CW[k] > 8)) acc = acc + scale / 2;
        return 8'((acc / scale) % 256);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            step();
            for (int k = 0; k < NUM; k++) begin
                vectors++;
                if (phase_obs[k] !== CO[k]) begin
                    miscompares++;
                    $display("FAIL reset[%0d] edge=%0d: got %0d expected %0d", k, e, phase_obs[k], CO[k]);
                end
            end
        end
    endtask

    task automatic test_count();
        logic [7:0] seq_trunc [6];
        logic [7:0] seq_round [6];
        seq_trunc = '{8'd1, 8'd3, 8'd4, 8'd6, 8'd7, 8'd9};
        seq_round = '{8'd2, 8'd3, 8'd5, 8'd6, 8'd8, 8'd9};
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            vectors++;
            if (phase_obs[0] !== 8'(e)) begin
                miscompares++;
                $display("FAIL count_default edge=%0d: got %0d expected %0d", e, phase_obs[0], e);
            end
            if (e <= 6) begin
                vectors++;
                if (phase_obs[1] !== seq_trunc[e-1]) begin
                    miscompares++;
                    $display("FAIL count_frac_trunc edge=%0d: got %0d expected %0d", e, phase_obs[1], seq_trunc[e-1]);
                end
                vectors++;
                if (phase_obs[2] !== seq_round[e-1]) begin
                    miscompares++;
                    $display("FAIL count_frac_round edge=%0d: got %0d expected %0d", e, phase_obs[2], seq_round[e-1]);
                end
            end
            for (int k = 3; k < NUM; k++) begin
                vectors++;
                if (phase_obs[k] !== model(k, n_inc)) begin
                    miscompares++;
                    $display("FAIL count[%0d] n=%0d: got %0d expected %0d", k, n_inc, phase_obs[k], model(k, n_inc));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        for (int k = 0; k < NUM; k++) begin
            vectors++;
            if (phase_obs[k] !== CO[k]) begin
                miscompares++;
                $display("FAIL mid_reset[%0d]: got %0d expected %0d", k, phase_obs[k], CO[k]);
            end
        end
        rst = 1'b0;
        step();
        vectors++;
        if (phase_obs[0] !== 8'd1) begin
            miscompares++;
            $display("FAIL mid_reset_resume: got %0d expected 1", phase_obs[0]);
        end
        vectors++;
        if (phase_obs[3] !== 8'd241) begin
            miscompares++;
            $display("FAIL mid_reset_resume_offset: got %0d expected 241", phase_obs[3]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] prev;
        bit         saw_wrap;
        prev     = phase_obs[0];
        saw_wrap = 1'b0;
        rst      = 1'b0;
        for (int e = 0; e < 260; e++) begin
            step();
            vectors++;
            if (phase_obs[0] !== 8'(prev + 8'd1)) begin
                miscompares++;
                $display("FAIL wrap_step edge=%0d: got %0d expected %0d", e, phase_obs[0], 8'(prev + 8'd1));
            end
            if ((prev == 8'd255) && (phase_obs[0] == 8'd0)) saw_wrap = 1'b1;
            prev = phase_obs[0];
            for (int k = 1; k < NUM; k++) begin
                vectors++;
                if (phase_obs[k] !== model(k, n_inc)) begin
                    miscompares++;
                    $display("FAIL wrap[%0d] n=%0d: got %0d expected %0d", k, n_inc, phase_obs[k], model(k, n_inc));
                end
            end
        end
        vectors++;
        if (saw_wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_seen: got %0d expected 1", saw_wrap);
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 400; e++) begin
            rst = ($urandom_range(0, 15) == 0);
            step();
            for (int k = 0; k < NUM; k++) begin
                vectors++;
                if (phase_obs[k] !== model(k, n_inc)) begin
                    miscompares++;
                    $display("FAIL random[%0d] n=%0d rst=%0b: got %0d expected %0d",
                             k, n_inc, rst, phase_obs[k], model(k, n_inc));
                end
            end
        end
    endtask

    task automatic test_reset_held();
        int len;
        len = int'($urandom_range(3, 8));
        rst = 1'b1;
        for (int e = 0; e < len; e++) begin
            step();
            for (int k = 0; k < NUM; k++) begin
                vectors++;
                if (phase_obs[k] !== CO[k]) begin
                    miscompares++;
                    $display("FAIL reset_held[%0d] edge=%0d: got %0d expected %0d", k, e, phase_obs[k], CO[k]);
                end
            end
        end
        rst = 1'b0;
        for (int e = 0; e < 50; e++) begin
            step();
            vectors++;
            if (phase_obs[4] !== CO[4]) begin
                miscompares++;
                $display("FAIL fcw_zero_hold edge=%0d: got %0d expected %0d", e, phase_obs[4], CO[4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_mid_reset();
        test_wrap();
        test_random();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/phase_generator.md
Name: phase_generator

Overview:
- Numerically controlled phase accumulator for the CDR.
- Produces an 8-bit sampling-phase code that advances by a fixed frequency control word every clock and wraps modulo 256.
- Feeds the downstream phase selector / interpolator.
- Free-running after reset; it has no data inputs.

Parameters:
- ACC_WIDTH, 16: internal accumulator width in bits. Legal range 8..32.
- FCW, 16'h0100: frequency control word added to the accumulator every cycle, interpreted modulo 2^ACC_WIDTH. The default advances phase by 1 LSB per cycle.
- PHASE_OFFSET, 8'h00: phase value loaded on reset.
- ROUND, 0: output quantisation mode. 0 truncates the accumulator to its top 8 bits. 1 rounds half-up to 8 bits, wrapping modulo 256.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- phase  output  8  current phase code, 0..255 covering one UI.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset (rst) is synchronous and active-high.
  - rst is sampled only on the rising edge of clk.
  - rst has priority over the increment.
- State:
  - A single register acc[ACC_WIDTH-1:0].
  - No other state and no state machine.
- Reset value:
  - On a rising edge with rst=1: acc <= {PHASE_OFFSET, (ACC_WIDTH-8) zeros}.
  - Therefore phase = PHASE_OFFSET after reset (default 0) in both ROUND modes.
- Update:
  - On a rising edge with rst=0: acc <= (acc + FCW) mod 2^ACC_WIDTH.
  - Carry out is discarded; no saturation.
- Output:
  - phase is a combinational slice of the acc register; no extra pipeline stage.
  - phase therefore changes on the same edge as acc, one cycle after the increment is enabled.
  - ROUND=0: phase = acc[ACC_WIDTH-1 -: 8].
  - ROUND=1: phase = (acc[ACC_WIDTH-1 -: 8] + acc[ACC_WIDTH-9]) mod 256. When ACC_WIDTH=8, no bit exists below the slice, so phase = acc.
- Latency:
  - The first rising edge with rst=0 after reset gives phase = PHASE_OFFSET + FCW/2^(ACC_WIDTH-8), truncated.
  - With defaults: 0 -> 1 on the first edge, then +1 per edge.
- Wrap-around: the output goes 255 -> 0 with no glitch or hold cycle. Fractional bits carry across the wrap unchanged.
- Reset mid-operation: a single cycle of rst=1 forces phase back to PHASE_OFFSET on that edge, regardless of the current value. The next non-reset edge resumes incrementing from there.
- Reset held: phase stays at PHASE_OFFSET for every edge on which rst=1.
- Before the first reset edge, phase is X in simulation. No power-on initialiser is used.
- FCW=0: phase holds at PHASE_OFFSET indefinitely; this is legal.
- Parameter checks: illegal ACC_WIDTH, or FCW wider than ACC_WIDTH, must cause an elaboration-time error (generate-time $error).
- Timing: all logic is a single adder plus a mux, meeting timing at the system clock with no multicycle paths.

Test Plan:
- Default params. clk period 10 (posedges at 5, 15, …). rst=1 for 0–20 -> phase=0 at edges 5 and 15. rst=0 at 20 -> phase = 1, 2, …, 10 at edges 25 … 115.
- After that run, assert rst=1 at 120 -> phase=0 at edge 125. Release rst -> phase=1 on the next edge.
- Default params, 260 cycles without reset -> phase reaches 255, then 0, 1, 2, 3. Check modulo-256 wrap with no repeated or skipped value.
- FCW=16'h0180, ROUND=0 -> phase sequence 0, 1, 3, 4, 6, 7, … (fraction carries). Same with ROUND=1 -> 0, 2, 3, 5, 6, 8, ….
- PHASE_OFFSET=8'hF0 -> phase=240 during reset; after release: 241 … 255, 0, 1.
- FCW=0 -> phase stays at PHASE_OFFSET for 50 cycles. Toggling rst mid-run changes nothing.
